// File: rtl/round_referee_if.sv
// round_referee_if: handshake between the referee and the move predictor.
//   comp_choice  predictor's committed move (00 rock, 01 scissors, 10 paper, 11 illegal)
//   comp_ready   high while comp_choice is stable and committed
//   start_n      active-low strobe from the referee; its falling edge makes the predictor learn
//   master: referee side, slave: predictor side
interface round_referee_if;
    logic [1:0] comp_choice;
    logic       comp_ready;
    logic       start_n;
    modport master (input comp_choice, input comp_ready, output start_n);
    modport slave (output comp_choice, output comp_ready, input start_n);
endinterface

// File: rtl/round_referee.sv
// round_referee: debounces the play key, runs one rock/scissors/paper round against the predictor,
// keeps scores up to WIN_SCORE and drives two active-low score digits.
//   clock        system clock
//   reset        asynchronous active-low reset
//   play_n       raw bouncing play key, active-low
//   user_move    user's move from the switches (11 illegal)
//   pred         predictor handshake (comp_choice, comp_ready in; start_n out)
//   round_valid  one-cycle pulse when outcome/scores/last moves update
//   outcome      00 tie, 01 user wins, 10 computer wins, 11 aborted/illegal
//   last_user, last_comp    moves of the most recent judged round
//   user_score, comp_score  binary scores 0..WIN_SCORE
//   game_over    set when either score reaches WIN_SCORE, cleared only by reset
//   hex_user, hex_comp      active-low segments {g,f,e,d,c,b,a}
// Build option: define SCORE_HEX_EN to decode the scores onto the digits; otherwise both digits are blank.
module round_referee #(
    parameter int DEBOUNCE_CYCLES    = 1000000,
    parameter int START_PULSE_CYCLES = 4,
    parameter int READY_TIMEOUT      = 255,
    parameter int WIN_SCORE          = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              play_n,
    input  logic [1:0]        user_move,
    round_referee_if.master   pred,
    output logic              round_valid,
    output logic [1:0]        outcome,
    output logic [1:0]        last_user,
    output logic [1:0]        last_comp,
    output logic [3:0]        user_score,
    output logic [3:0]        comp_score,
    output logic              game_over,
    output logic [6:0]        hex_user,
    output logic [6:0]        hex_comp
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMAX = READY_TIMEOUT > START_PULSE_CYCLES ? READY_TIMEOUT : START_PULSE_CYCLES;
    localparam int TW = $clog2(TMAX + 1);
    localparam logic [3:0] WS = 4'(WIN_SCORE);

    typedef enum logic [2:0] {IDLE, WAIT_READY, PULSE, JUDGE, RELEASE} state_t;

    state_t state, next;
    logic [1:0] sync;
    logic deb, deb_d, press;
    logic [DW-1:0] dcnt;
    logic [TW-1:0] cnt;
    logic [1:0] u_q, c_q, j_user, j_comp, outcome_d;
    logic judge, j_abort, cap_u, cap_c, u_win, c_win;

    // The counter only advances while the synchronized key disagrees with the accepted level,
    // so any bounce back to the accepted level restarts the stability window.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync <= 2'b11;
            deb <= 1'b1;
            deb_d <= 1'b1;
            dcnt <= '0;
        end else begin
            sync <= {sync[0], play_n};
            deb_d <= deb;
            if (sync[1] == deb)
                dcnt <= '0;
            else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                deb <= sync[1];
                dcnt <= '0;
            end else
                dcnt <= dcnt + 1'b1;
        end
    end

    assign press = deb_d & ~deb;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= next;
            cnt <= (next != state) ? '0 : cnt + 1'b1;
        end
    end

    // Result of the round is resolved on the transition into JUDGE so round_valid
    // is high during the JUDGE cycle itself.
    always_comb begin
        next = state;
        judge = 1'b0;
        j_user = u_q;
        j_comp = c_q;
        j_abort = 1'b0;
        cap_u = 1'b0;
        cap_c = 1'b0;
        case (state)
            IDLE:
                if (press && !game_over) begin
                    if (user_move == 2'b11) begin
                        next = JUDGE;
                        judge = 1'b1;
                        j_user = user_move;
                        j_comp = 2'b00;
                        j_abort = 1'b1;
                    end else begin
                        next = WAIT_READY;
                        cap_u = 1'b1;
                    end
                end
            WAIT_READY:
                if (pred.comp_ready) begin
                    if (pred.comp_choice == 2'b11) begin
                        next = JUDGE;
                        judge = 1'b1;
                        j_comp = 2'b11;
                        j_abort = 1'b1;
                    end else begin
                        next = PULSE;
                        cap_c = 1'b1;
                    end
                end else if (cnt == TW'(READY_TIMEOUT - 1)) begin
                    next = JUDGE;
                    judge = 1'b1;
                    j_comp = 2'b00;
                    j_abort = 1'b1;
                end
            PULSE:
                if (cnt == TW'(START_PULSE_CYCLES - 1)) begin
                    next = JUDGE;
                    judge = 1'b1;
                end
            JUDGE:
                next = RELEASE;
            RELEASE:
                if (deb) next = IDLE;
            default:
                next = IDLE;
        endcase
    end

    assign u_win = !j_abort && ((j_user == 2'b00 && j_comp == 2'b01) ||
                                (j_user == 2'b01 && j_comp == 2'b10) ||
                                (j_user == 2'b10 && j_comp == 2'b00));
    assign c_win = !j_abort && ((j_comp == 2'b00 && j_user == 2'b01) ||
                                (j_comp == 2'b01 && j_user == 2'b10) ||
                                (j_comp == 2'b10 && j_user == 2'b00));
    assign outcome_d = j_abort ? 2'b11 : u_win ? 2'b01 : c_win ? 2'b10 : 2'b00;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            u_q <= 2'b00;
            c_q <= 2'b00;
            pred.start_n <= 1'b1;
            round_valid <= 1'b0;
            outcome <= 2'b00;
            last_user <= 2'b00;
            last_comp <= 2'b00;
            user_score <= 4'd0;
            comp_score <= 4'd0;
            game_over <= 1'b0;
        end else begin
            if (cap_u) u_q <= user_move;
            if (cap_c) c_q <= pred.comp_choice;
            pred.start_n <= (next != PULSE);
            round_valid <= judge;
            if (judge) begin
                outcome <= outcome_d;
                last_user <= j_user;
                last_comp <= j_comp;
                if (u_win && user_score != WS) user_score <= user_score + 4'd1;
                if (c_win && comp_score != WS) comp_score <= comp_score + 4'd1;
                if ((u_win && user_score == WS - 4'd1) || (c_win && comp_score == WS - 4'd1))
                    game_over <= 1'b1;
            end
        end
    end

`ifdef SCORE_HEX_EN
    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = 7'h7F;
        endcase
    endfunction

    assign hex_user = seg(user_score);
    assign hex_comp = seg(comp_score);
`else
    assign hex_user = 7'h7F;
    assign hex_comp = 7'h7F;
`endif
endmodule

// File: tb/tb_round_referee.sv
// tb_round_referee: scoreboard bench for round_referee with short debounce/timeout parameters.
module tb_round_referee;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic play_n = 1'b1;
    logic [1:0] user_move = 2'b00;
    logic round_valid, game_over;
    logic [1:0] outcome, last_user, last_comp;
    logic [3:0] user_score, comp_score;
    logic [6:0] hex_user, hex_comp;

    typedef struct {
        logic [1:0] oc;
        logic [3:0] us;
        logic [3:0] cs;
        logic       go;
        logic       cl;
        logic [1:0] lu;
        logic [1:0] lc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int rounds = 0;
    int low_cnt = 0;
    int p0, r0;

    round_referee_if pred();

    always #5 clock = ~clock;

    round_referee #(
        .DEBOUNCE_CYCLES(4),
        .START_PULSE_CYCLES(4),
        .READY_TIMEOUT(8),
        .WIN_SCORE(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .play_n(play_n),
        .user_move(user_move),
        .pred(pred.master),
        .round_valid(round_valid),
        .outcome(outcome),
        .last_user(last_user),
        .last_comp(last_comp),
        .user_score(user_score),
        .comp_score(comp_score),
        .game_over(game_over),
        .hex_user(hex_user),
        .hex_comp(hex_comp)
    );

    function automatic logic [6:0] hexd(input int v);
`ifdef SCORE_HEX_EN
        logic [6:0] t[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return t[v];
`else
        return 7'h7F;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic expect_round(input logic [1:0] oc, input int us, input int cs, input logic go,
                                input logic cl, input logic [1:0] lu, input logic [1:0] lc);
        exp_t x;
        x.oc = oc; x.us = 4'(us); x.cs = 4'(cs); x.go = go; x.cl = cl; x.lu = lu; x.lc = lc;
        q.push_back(x);
    endtask

    task automatic press(input int hold, input int rel);
        play_n = 1'b0;
        repeat (hold) @(negedge clock);
        play_n = 1'b1;
        repeat (rel) @(negedge clock);
    endtask

    always @(negedge clock) begin
        if (!reset)
            low_cnt = 0;
        else begin
            if (!pred.start_n)
                low_cnt++;
            else if (low_cnt != 0) begin
                pulses++;
                chk("pulse_len", low_cnt, 4);
                chk("valid_after_pulse", round_valid, 1);
                low_cnt = 0;
            end
            if (round_valid) begin
                rounds++;
                chk("round_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("outcome", outcome, e.oc);
                    chk("user_score", user_score, e.us);
                    chk("comp_score", comp_score, e.cs);
                    chk("game_over", game_over, e.go);
                    chk("hex_user", hex_user, hexd(int'(e.us)));
                    chk("hex_comp", hex_comp, hexd(int'(e.cs)));
                    if (e.cl) begin
                        chk("last_user", last_user, e.lu);
                        chk("last_comp", last_comp, e.lc);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        pred.comp_choice = 2'b01;
        pred.comp_ready = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_start_n", pred.start_n, 1);
        chk("rst_valid", round_valid, 0);
        chk("rst_outcome", outcome, 0);
        chk("rst_user_score", user_score, 0);
        chk("rst_comp_score", comp_score, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_hex_user", hex_user, hexd(0));
        chk("rst_hex_comp", hex_comp, hexd(0));
        repeat (20) @(negedge clock);
        chk("idle_rounds", rounds, 0);

        user_move = 2'b00;
        pred.comp_choice = 2'b01;
        p0 = pulses; r0 = rounds;
        expect_round(2'b01, 1, 0, 0, 1, 2'b00, 2'b01);
        press(20, 20);
        chk("clean_pulses", pulses - p0, 1);
        chk("clean_rounds", rounds - r0, 1);

        p0 = pulses; r0 = rounds;
        expect_round(2'b01, 2, 0, 0, 1, 2'b00, 2'b01);
        for (int i = 0; i < 10; i++) begin
            play_n = (i % 2 == 1);
            repeat (2) @(negedge clock);
        end
        press(120, 20);
        chk("bounce_pulses", pulses - p0, 1);
        chk("bounce_rounds", rounds - r0, 1);

        user_move = 2'b11;
        p0 = pulses; r0 = rounds;
        expect_round(2'b11, 2, 0, 0, 0, 2'b00, 2'b00);
        press(20, 20);
        chk("illegal_pulses", pulses - p0, 0);
        chk("illegal_rounds", rounds - r0, 1);

        user_move = 2'b00;
        pred.comp_ready = 1'b0;
        p0 = pulses; r0 = rounds;
        expect_round(2'b11, 2, 0, 0, 0, 2'b00, 2'b00);
        press(30, 20);
        chk("timeout_pulses", pulses - p0, 0);
        chk("timeout_rounds", rounds - r0, 1);

        pred.comp_ready = 1'b1;
        user_move = 2'b01;
        pred.comp_choice = 2'b01;
        p0 = pulses;
        expect_round(2'b00, 2, 0, 0, 1, 2'b01, 2'b01);
        press(20, 20);
        chk("tie_pulses", pulses - p0, 1);

        user_move = 2'b10;
        pred.comp_choice = 2'b01;
        expect_round(2'b10, 2, 1, 0, 1, 2'b10, 2'b01);
        press(20, 20);
        expect_round(2'b10, 2, 2, 0, 1, 2'b10, 2'b01);
        press(20, 20);
        expect_round(2'b10, 2, 3, 1, 1, 2'b10, 2'b01);
        press(20, 20);
        p0 = pulses; r0 = rounds;
        press(20, 20);
        chk("over_pulses", pulses - p0, 0);
        chk("over_rounds", rounds - r0, 0);
        chk("over_held", game_over, 1);

        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rst2_game_over", game_over, 0);
        user_move = 2'b00;
        pred.comp_choice = 2'b01;
        p0 = pulses; r0 = rounds;
        play_n = 1'b0;
        for (int i = 0; i < 40 && pred.start_n; i++) @(negedge clock);
        chk("mid_pulse_reached", pred.start_n, 0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        play_n = 1'b1;
        #1;
        chk("mid_rst_start_n", pred.start_n, 1);
        chk("mid_rst_user_score", user_score, 0);
        chk("mid_rst_comp_score", comp_score, 0);
        chk("mid_rst_outcome", outcome, 0);
        chk("mid_rst_hex_comp", hex_comp, hexd(0));
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (30) @(negedge clock);
        chk("post_rst_pulses", pulses - p0, 0);
        chk("post_rst_rounds", rounds - r0, 0);
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
